// File: rtl/dmem_responder.sv
// Data-port responder: word-wide RAM served after WAIT_STATES wait cycles, one-cycle mem_ready.
// Define DMEM_ERR_CHECK_EN to enable alignment/window checking that drives mem_err.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic                    err_q, err_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    enter_done;
  logic                    ram_we;
  logic                    req_err;
  logic [31:0]             ram [DEPTH];

`ifdef DMEM_ERR_CHECK_EN
  assign req_err = (data_addr[1:0] != 2'b00) ||
                   (data_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
`else
  // Upper and byte-lane address bits alias freely when checking is off.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_addr[1:0], data_addr[31:ADDR_WIDTH+2], BASE_ADDR};
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    enter_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = data_addr[ADDR_WIDTH+1:2];
          wdata_d = data_in;
          wr_d    = mem_write;
          rd_d    = mem_read && !mem_write;
          err_d   = req_err;
          cnt_d   = '0;
          if (WAIT_STATES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The RAM access happens on the edge entering DONE; the *_d values hold the
  // effective operation there, covering both the latched and zero-wait cases.
  always_comb begin
    data_out_d = data_out_q;
    if (enter_done && rd_d) begin
      data_out_d = err_d ? '0 : ram[idx_d];
    end
  end

  assign ram_we = enter_done && wr_d && !err_d && !reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[idx_d] <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign mem_ready = (state_q == S_DONE);
  assign mem_err   = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
// Follows DMEM_ERR_CHECK_EN to pick the expected error/aliasing behaviour.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, rd2, wr2, rdy2, err2;
  logic [31:0] addr2, din2, dout2;
  logic        rst0, rd0, wr0, rdy0, err0;
  logic [31:0] addr0, din0, dout0;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0000_1000)) dut2 (
    .clk(clk), .reset(rst2), .data_addr(addr2), .data_in(din2),
    .mem_read(rd2), .mem_write(wr2), .data_out(dout2), .mem_ready(rdy2), .mem_err(err2)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) dut0 (
    .clk(clk), .reset(rst0), .data_addr(addr0), .data_in(din0),
    .mem_read(rd0), .mem_write(wr0), .data_out(dout0), .mem_ready(rdy0), .mem_err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with dut2 idle; returns at a negedge one cycle after the pulse.
  task automatic txn2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] dout, output logic err,
                      output logic pulse_ok);
    rd2 = rd; wr2 = wr; addr2 = a; din2 = d;
    lat = 99; dout = 'x; err = 1'bx;
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        rd2 = 1'b0; wr2 = 1'b0; addr2 = $urandom; din2 = $urandom;
      end
      if (rdy2) begin
        lat = i; dout = dout2; err = err2;
        break;
      end
    end
    @(negedge clk);
    pulse_ok = !rdy2;
  endtask

  int          lat;
  logic [31:0] dout;
  logic        err, pok;
  int          npulse;
  logic [5:0]  pattern;

  initial begin
    rst2 = 1'b1; rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
    rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", dout2, 32'h0);
    check("rst_ready", 32'(rdy2), 32'h0);
    check("rst_err", 32'(err2), 32'h0);
    rst2 = 1'b0; rst0 = 1'b0;
    npulse = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy2 || rdy0) npulse++;
    end
    check("idle_no_ready", 32'(npulse), 32'h0);

    // Store then load with two wait states
    txn2(1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, lat, dout, err, pok);
    check("st_latency", 32'(lat), 32'd3);
    check("st_err", 32'(err), 32'h0);
    check("st_pulse_one", 32'(pok), 32'h1);
    check("st_keeps_dout", dout2, 32'h0);
    txn2(1'b1, 1'b0, 32'h0000_1004, 32'h0, lat, dout, err, pok);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_data", dout, 32'hCAFE_F00D);
    check("ld_pulse_one", 32'(pok), 32'h1);
    check("ld_data_hold", dout2, 32'hCAFE_F00D);

    // Read and write together acts as a store
    txn2(1'b1, 1'b1, 32'h0000_100C, 32'h1234_5678, lat, dout, err, pok);
    check("rw_latency", 32'(lat), 32'd3);
    check("rw_dout_unchanged", dout2, 32'hCAFE_F00D);
    txn2(1'b1, 1'b0, 32'h0000_100C, 32'h0, lat, dout, err, pok);
    check("rw_readback", dout, 32'h1234_5678);

    // Reset during WAIT drops the store
    txn2(1'b0, 1'b1, 32'h0000_1010, 32'h1111_2222, lat, dout, err, pok);
    wr2 = 1'b1; addr2 = 32'h0000_1010; din2 = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    wr2 = 1'b0;
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy2) npulse++;
    end
    check("abort_no_ready", 32'(npulse), 32'h0);
    check("abort_dout_reset", dout2, 32'h0);
    txn2(1'b1, 1'b0, 32'h0000_1010, 32'h0, lat, dout, err, pok);
    check("abort_old_data", dout, 32'h1111_2222);

    // Address checking or aliasing
    txn2(1'b0, 1'b1, 32'h0000_1000, 32'h5A5A_0001, lat, dout, err, pok);
    check("w0_err", 32'(err), 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    txn2(1'b1, 1'b0, 32'h0000_1002, 32'h0, lat, dout, err, pok);
    check("mis_latency", 32'(lat), 32'd3);
    check("mis_err", 32'(err), 32'h1);
    check("mis_dout_zero", dout, 32'h0);
    txn2(1'b0, 1'b1, 32'h0000_9000, 32'h7777_8888, lat, dout, err, pok);
    check("oow_latency", 32'(lat), 32'd3);
    check("oow_err", 32'(err), 32'h1);
    txn2(1'b1, 1'b0, 32'h0000_1000, 32'h0, lat, dout, err, pok);
    check("w0_unmodified", dout, 32'h5A5A_0001);
    check("w0_ld_err", 32'(err), 32'h0);
`else
    txn2(1'b1, 1'b0, 32'h0000_1002, 32'h0, lat, dout, err, pok);
    check("mis_alias", dout, 32'h5A5A_0001);
    check("mis_err", 32'(err), 32'h0);
    txn2(1'b0, 1'b1, 32'h0000_9000, 32'h7777_8888, lat, dout, err, pok);
    check("oow_err", 32'(err), 32'h0);
    txn2(1'b1, 1'b0, 32'h0000_1000, 32'h0, lat, dout, err, pok);
    check("oow_alias", dout, 32'h7777_8888);
`endif

    // Zero wait states: store, then a held read yields a pulse every other cycle
    wr0 = 1'b1; addr0 = 32'h0000_1008; din0 = 32'h0BAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    wr0 = 1'b0;
    check("ws0_st_ready", 32'(rdy0), 32'h1);
    @(negedge clk);
    check("ws0_st_pulse_one", 32'(rdy0), 32'h0);
    rd0 = 1'b1; addr0 = 32'h0000_1008;
    pattern = '0;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pattern[i] = rdy0;
      if (rdy0) npulse++;
    end
    rd0 = 1'b0;
    check("ws0_pattern", 32'(pattern), 32'h15);
    check("ws0_pulses", 32'(npulse), 32'd3);
    check("ws0_data", dout0, 32'h0BAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
